// File: rtl/itch_serializer.sv
// Serialises one decoded ITCH order message into a 19-byte length-prefixed frame.
// Optional PRICE_FILTER_EN: drop messages priced below PRICE_THRESHOLD.
module itch_serializer #(
  parameter logic [15:0] LEN_FIELD       = 16'd17,
  parameter logic [3:0]  INTER_FRAME_GAP = 4'd0,
  parameter logic [31:0] PRICE_THRESHOLD = 32'd100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [7:0]  msg_type,
  input  logic [63:0] order_id,
  input  logic [31:0] price,
  input  logic [31:0] size,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [15:0] frames_sent,
  output logic [15:0] dropped_count
);

  // state  | meaning
  // IDLE   | waiting for a message, msg_ready high
  // LEN_HI | sending LEN_FIELD[15:8]
  // LEN_LO | sending LEN_FIELD[7:0]
  // TYPE   | sending the message type byte
  // PAYLD  | sending order_id, price, size MSB first (idx 0..15)
  // GAP    | forced idle cycles before the next message
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, TYPE, PAYLD, GAP} state_t;

  state_t        state, state_nx;
  logic [7:0]    type_q;
  logic [127:0]  payld_q;
  logic [127:0]  payld_sh;
  logic [3:0]    idx;
  logic [3:0]    gap_cnt;
  logic          accept, xfer, drop, last_xfer;

  assign accept    = msg_valid && msg_ready;
  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && (state == PAYLD) && (idx == 4'd15);

`ifdef PRICE_FILTER_EN
  assign drop = price < PRICE_THRESHOLD;
`else
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !drop) state_nx = LEN_HI;
      LEN_HI:  if (xfer) state_nx = LEN_LO;
      LEN_LO:  if (xfer) state_nx = TYPE;
      TYPE:    if (xfer) state_nx = PAYLD;
      PAYLD:   if (last_xfer) state_nx = (INTER_FRAME_GAP != 4'd0) ? GAP : IDLE;
      GAP:     if (gap_cnt == 4'd0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // msg_ready is gated by rst_n so it reads 0 while reset is held
  always_comb begin
    msg_ready = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_byte  = 8'h00;
    payld_sh  = payld_q << {idx, 3'b000};
    case (state)
      IDLE:   msg_ready = rst_n;
      LEN_HI: begin out_valid = 1'b1; out_byte = LEN_FIELD[15:8]; end
      LEN_LO: begin out_valid = 1'b1; out_byte = LEN_FIELD[7:0];  end
      TYPE:   begin out_valid = 1'b1; out_byte = type_q;          end
      PAYLD: begin
        out_valid = 1'b1;
        out_byte  = payld_sh[127:120];
        out_last  = (idx == 4'd15);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q  <= 8'h00;
      payld_q <= '0;
      idx     <= 4'd0;
      gap_cnt <= 4'd0;
    end else begin
      if (accept && !drop) begin
        type_q  <= msg_type;
        payld_q <= {order_id, price, size};
      end
      if (state == TYPE && xfer)       idx <= 4'd0;
      else if (state == PAYLD && xfer) idx <= idx + 4'd1;
      if (last_xfer)                   gap_cnt <= INTER_FRAME_GAP - 4'd1;
      else if (state == GAP)           gap_cnt <= gap_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_sent   <= 16'd0;
      dropped_count <= 16'd0;
    end else begin
      if (last_xfer)       frames_sent   <= frames_sent + 16'd1;
      if (accept && drop)  dropped_count <= dropped_count + 16'd1;
    end
  end

endmodule

// File: doc/itch_serializer.md
Name: itch_serializer

Overview:
- Transmit-side counterpart of the ITCH-style byte-stream parser.
- Accepts one decoded order message per handshake (type, order_id, price, size) and serialises it into a framed byte stream, one byte per cycle.
- Frame layout: 16-bit length, 1 type byte, 16 payload bytes.
- Sits between strategy/order-generation logic and the byte-wide link or loopback into the parser.

Parameters:
- LEN_FIELD, 16'd17, value sent in the length field: bytes following the length field (type + 16 payload).
- INTER_FRAME_GAP, 4'd0, idle cycles forced after each frame's last byte before the next message is accepted.
- PRICE_THRESHOLD, 32'd100000, minimum price forwarded when PRICE_FILTER_EN is defined.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- msg_valid  input  1  message fields valid
- msg_ready  output  1  serializer can accept a message this cycle
- msg_type  input  8  ITCH message type byte
- order_id  input  64  order identifier
- price  input  32  price
- size  input  32  quantity
- out_byte  output  8  serialized byte
- out_valid  output  1  out_byte valid
- out_ready  input  1  downstream accepts byte
- out_last  output  1  high with the final byte of a frame
- frames_sent  output  16  count of completed frames, wraps
- dropped_count  output  16  count of filtered messages, wraps

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state IDLE
  - msg_ready 0 during reset, 1 in the first IDLE cycle after deassertion
  - out_valid 0, out_last 0, out_byte 8'h00
  - frames_sent 0, dropped_count 0
  - shadow registers 0
- States: IDLE, LEN_HI, LEN_LO, TYPE, PAYLD, GAP.
- IDLE:
  - msg_ready=1, out_valid=0.
  - On msg_valid && msg_ready, capture all fields into shadow registers and go to LEN_HI.
  - Input fields may change afterwards without affecting the frame.
- Latency: the first byte (LEN_HI) has out_valid=1 in the cycle after acceptance.
- Byte order, each byte advancing only on out_valid && out_ready:
  - LEN_HI sends LEN_FIELD[15:8].
  - LEN_LO sends LEN_FIELD[7:0].
  - TYPE sends the type byte.
  - PAYLD sends, MSB first: order_id[63:56] … order_id[7:0], price[31:24] … price[7:0], size[31:24] … size[7:0].
  - PAYLD uses a 4-bit index, 0..15.
- Frame totals: 19 bytes, minimum 19 cycles at out_ready=1.
- Output stability: while out_valid && !out_ready, out_byte, out_last and state hold.
- out_valid is never dropped before its byte is accepted.
- Backpressure of any length is legal at any byte.
- out_last=1 only on PAYLD index 15.
- On acceptance of the last byte:
  - frames_sent increments; 16'hFFFF wraps to 0.
  - Next state is GAP if INTER_FRAME_GAP>0, else IDLE.
- GAP:
  - msg_ready=0, out_valid=0.
  - Counts INTER_FRAME_GAP cycles, then returns to IDLE.
- msg_ready is 0 in every state except IDLE. No pipelining of the next message during a frame.
- A message presented with msg_valid while busy is not consumed. Upstream holds it.
- Reset mid-frame: partial frame abandoned immediately; no out_last is emitted. Counters clear.
- out_ready high while out_valid=0 has no effect.

Optional Feature:
- Macro: PRICE_FILTER_EN.
- Defined:
  - In IDLE, a message is still accepted (msg_ready=1).
  - If price < PRICE_THRESHOLD, it is discarded: no bytes emitted, dropped_count increments, state stays IDLE, msg_ready stays 1 next cycle.
  - price == PRICE_THRESHOLD is forwarded.
- Not defined:
  - All messages are serialised.
  - dropped_count is tied to 0.

Test Plan:
- Basic frame, out_ready=1, message (type 8'h41, order_id 64'h0102030405060708, price 32'h000186A0, size 32'h00000064):
  - Bytes 00 11 41 01 02 03 04 05 06 07 08 00 01 86 A0 00 00 00 64 on 19 consecutive cycles.
  - out_last on byte 19 only; frames_sent=1.
- Backpressure: out_ready low for 5 cycles at the TYPE byte and 3 cycles at payload index 9:
  - out_byte holds 8'h41 (then the price byte) unchanged.
  - No byte duplicated or lost.
  - Frame completes in 27 cycles.
- Back-to-back, INTER_FRAME_GAP=3, two messages held valid:
  - Second accepted exactly 4 cycles after the first frame's last byte (3 gap cycles + the IDLE acceptance cycle).
  - msg_ready=0 throughout the first frame and the gap.
- Reset mid-frame: assert rst_n=0 at payload index 6:
  - out_valid falls asynchronously, frames_sent=0.
  - After release, a new message produces a complete 19-byte frame.
- PRICE_FILTER_EN defined, PRICE_THRESHOLD=100000:
  - price 99999 → no output, dropped_count=1.
  - price 100000 → full frame, frames_sent=1.
- frames_sent wrap: preload by sending 65536 frames → counter reads 0.
- Loopback: serializer output into the parser yields matching msg_type/order_id/price/size with msg_valid.
